// File: rtl/sync_fifo_pkg.sv
// Shared helpers for the sync_fifo_flags slice: pointer sizing, depth legality,
// and default almost-full/almost-empty thresholds.
package sync_fifo_pkg;

  localparam int MIN_DEPTH     = 2;
  localparam int AF_MARGIN     = 2;  // default almost_full sits this far below DEPTH
  localparam int DEF_AE_THRESH = 2;

  // Pointer carries one extra wrap bit above the memory address.
  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic bit depth_ok(input int depth);
    return (depth >= MIN_DEPTH) && ((depth & (depth - 1)) == 0);
  endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// DEPTH x WIDTH register array: one synchronous write port, one asynchronous
// read port. Contents are intentionally not reset.
module sync_fifo_mem #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [DEPTH-1:0][WIDTH-1:0] mem;

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with count, almost-full/empty thresholds and sticky error
// flags. Define SYNC_FIFO_FWFT_EN for first-word-fall-through output.
module sync_fifo_flags
  import sync_fifo_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int DEPTH     = 16,
  parameter int AF_THRESH = DEPTH - AF_MARGIN,
  parameter int AE_THRESH = DEF_AE_THRESH,
  localparam int PW       = ptr_w(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] data_in,
  input  logic             rd_en,
  output logic [WIDTH-1:0] data_out,
  output logic             full,
  output logic             empty,
  output logic             almost_full,
  output logic             almost_empty,
  output logic [PW-1:0]    count,
  output logic             overflow,
  output logic             underflow,
  input  logic             err_clr
);

  localparam int AW = PW - 1;
  localparam logic [PW-1:0] AF_T = PW'(AF_THRESH);
  localparam logic [PW-1:0] AE_T = PW'(AE_THRESH);

  if (!depth_ok(DEPTH)) begin : g_bad_depth
    $error("sync_fifo_flags: DEPTH must be a power of two >= 2");
  end
  if (AE_THRESH >= AF_THRESH) begin : g_bad_thresh
    $error("sync_fifo_flags: AE_THRESH must be below AF_THRESH");
  end

  logic [PW-1:0]    wr_ptr, rd_ptr, count_q;
  logic             wr_acc, rd_acc;
  logic [AW-1:0]    rd_addr;
  logic [WIDTH-1:0] mem_rdata;
  logic [WIDTH-1:0] dout_q;

  // Flags come only from registered pointers/count, never from wr_en/rd_en.
  assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign empty = (wr_ptr == rd_ptr);
  assign almost_full  = (count_q >= AF_T);
  assign almost_empty = (count_q <= AE_T);
  assign count    = count_q;
  assign data_out = dout_q;

  assign wr_acc = wr_en && !full;
  assign rd_acc = rd_en && !empty;

`ifdef SYNC_FIFO_FWFT_EN
  // Look one entry past the head so the register can preload the next word on a pop.
  assign rd_addr = rd_ptr[AW-1:0] + AW'(1);
`else
  assign rd_addr = rd_ptr[AW-1:0];
`endif

  sync_fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (wr_acc),
    .waddr (wr_ptr[AW-1:0]),
    .wdata (data_in),
    .raddr (rd_addr),
    .rdata (mem_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + PW'(1);
      if (rd_acc) rd_ptr <= rd_ptr + PW'(1);
      case ({wr_acc, rd_acc})
        2'b10:   count_q <= count_q + PW'(1);
        2'b01:   count_q <= count_q - PW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // A new error in the same cycle as err_clr wins, so no event is lost.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_en && full)     overflow <= 1'b1;
      else if (err_clr)      overflow <= 1'b0;
      if (rd_en && empty)    underflow <= 1'b1;
      else if (err_clr)      underflow <= 1'b0;
    end
  end

`ifdef SYNC_FIFO_FWFT_EN
  // Head register: preload from memory on a pop, or bypass data_in when the
  // incoming word becomes the new head (empty FIFO, or last word popped).
  always_ff @(posedge clk) begin
    if (rst) begin
      dout_q <= '0;
    end else if (rd_acc) begin
      if (count_q != PW'(1)) dout_q <= mem_rdata;
      else if (wr_acc)       dout_q <= data_in;
    end else if (empty && wr_acc) begin
      dout_q <= data_in;
    end
  end
`else
  always_ff @(posedge clk) begin
    if (rst)         dout_q <= '0;
    else if (rd_acc) dout_q <= mem_rdata;
  end
`endif

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Directed bench for sync_fifo_flags (default, standard-latency build).
module tb_sync_fifo_flags;

  localparam int WIDTH = 32;
  localparam int DEPTH = 16;
  localparam int PW    = 5;

  logic             clk = 1'b0;
  logic             rst, wr_en, rd_en, err_clr;
  logic [WIDTH-1:0] data_in, data_out;
  logic             full, empty, almost_full, almost_empty, overflow, underflow;
  logic [PW-1:0]    count;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  sync_fifo_flags #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .wr_en        (wr_en),
    .data_in      (data_in),
    .rd_en        (rd_en),
    .data_out     (data_out),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .count        (count),
    .overflow     (overflow),
    .underflow    (underflow),
    .err_clr      (err_clr)
  );

  // Advance one edge; outputs are then examined 1ns after it.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en = 1'b0; rd_en = 1'b0; err_clr = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
  endtask

  task automatic push(input logic [WIDTH-1:0] d);
    wr_en = 1'b1; data_in = d;
    cyc();
    wr_en = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (count !== 5'd0) begin n_bad++; $display("FAIL reset_count got %0d want 0", count); end
    n_cmp++; if ({empty, almost_empty, full, almost_full} !== 4'b1100) begin
      n_bad++; $display("FAIL reset_flags got e/ae/f/af=%b want 1100", {empty, almost_empty, full, almost_full}); end
    n_cmp++; if ({overflow, underflow} !== 2'b00) begin n_bad++; $display("FAIL reset_err got %b want 00", {overflow, underflow}); end
    n_cmp++; if (data_out !== 32'h0) begin n_bad++; $display("FAIL reset_dout got %h want 0", data_out); end
  endtask

  task automatic test_fill_drain();
    for (int i = 0; i < DEPTH; i++) begin
      push(32'(i));
      n_cmp++; if (count !== 5'(i + 1)) begin n_bad++; $display("FAIL fill_count[%0d] got %0d want %0d", i, count, i + 1); end
      n_cmp++; if (almost_full !== (i + 1 >= 14)) begin n_bad++; $display("FAIL fill_af[%0d] got %b want %b", i, almost_full, (i + 1 >= 14)); end
      n_cmp++; if (almost_empty !== (i + 1 <= 2)) begin n_bad++; $display("FAIL fill_ae[%0d] got %b want %b", i, almost_empty, (i + 1 <= 2)); end
      n_cmp++; if (full !== (i == DEPTH - 1)) begin n_bad++; $display("FAIL fill_full[%0d] got %b want %b", i, full, (i == DEPTH - 1)); end
    end
    // 17th write must be dropped and flagged
    push(32'hAA);
    n_cmp++; if (overflow !== 1'b1) begin n_bad++; $display("FAIL ovf_set got %b want 1", overflow); end
    n_cmp++; if (count !== 5'd16) begin n_bad++; $display("FAIL ovf_count got %0d want 16", count); end
    cyc();
    n_cmp++; if (overflow !== 1'b1) begin n_bad++; $display("FAIL ovf_sticky got %b want 1", overflow); end
    err_clr = 1'b1; cyc(); err_clr = 1'b0;
    n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL ovf_clr got %b want 0", overflow); end
    for (int i = 0; i < DEPTH; i++) begin
      rd_en = 1'b1; cyc(); rd_en = 1'b0;
      n_cmp++; if (data_out !== 32'(i)) begin n_bad++; $display("FAIL drain_data[%0d] got %h want %h", i, data_out, i); end
    end
    n_cmp++; if ({empty, count} !== {1'b1, 5'd0}) begin n_bad++; $display("FAIL drain_empty got e=%b cnt=%0d want e=1 cnt=0", empty, count); end
  endtask

  task automatic test_underflow();
    rd_en = 1'b1; cyc(); rd_en = 1'b0;
    n_cmp++; if (underflow !== 1'b1) begin n_bad++; $display("FAIL udf_set got %b want 1", underflow); end
    n_cmp++; if (data_out !== 32'hF) begin n_bad++; $display("FAIL udf_dout got %h want f", data_out); end
    n_cmp++; if (count !== 5'd0) begin n_bad++; $display("FAIL udf_count got %0d want 0", count); end
    // New error coinciding with err_clr keeps the flag set
    rd_en = 1'b1; err_clr = 1'b1; cyc(); idle();
    n_cmp++; if (underflow !== 1'b1) begin n_bad++; $display("FAIL udf_clr_race got %b want 1", underflow); end
    err_clr = 1'b1; cyc(); err_clr = 1'b0;
    n_cmp++; if (underflow !== 1'b0) begin n_bad++; $display("FAIL udf_clr got %b want 0", underflow); end
  endtask

  task automatic test_simultaneous();
    for (int i = 0; i < DEPTH; i++) push(32'h100 + 32'(i));
    wr_en = 1'b1; rd_en = 1'b1; data_in = 32'h1FF; cyc(); idle();
    n_cmp++; if (count !== 5'd15) begin n_bad++; $display("FAIL full_both_count got %0d want 15", count); end
    n_cmp++; if (overflow !== 1'b1) begin n_bad++; $display("FAIL full_both_ovf got %b want 1", overflow); end
    n_cmp++; if (data_out !== 32'h100) begin n_bad++; $display("FAIL full_both_dout got %h want 100", data_out); end
    err_clr = 1'b1; cyc(); err_clr = 1'b0;
    for (int i = 1; i < DEPTH; i++) begin
      rd_en = 1'b1; cyc(); rd_en = 1'b0;
      n_cmp++; if (data_out !== 32'h100 + 32'(i)) begin n_bad++; $display("FAIL full_both_drain[%0d] got %h want %h", i, data_out, 32'h100 + 32'(i)); end
    end
    wr_en = 1'b1; rd_en = 1'b1; data_in = 32'h77; cyc(); idle();
    n_cmp++; if (count !== 5'd1) begin n_bad++; $display("FAIL empty_both_count got %0d want 1", count); end
    n_cmp++; if (underflow !== 1'b1) begin n_bad++; $display("FAIL empty_both_udf got %b want 1", underflow); end
    n_cmp++; if (data_out !== 32'h10F) begin n_bad++; $display("FAIL empty_both_dout got %h want 10f", data_out); end
    rd_en = 1'b1; cyc(); rd_en = 1'b0;
    n_cmp++; if (data_out !== 32'h77) begin n_bad++; $display("FAIL empty_both_pop got %h want 77", data_out); end
  endtask

  task automatic test_back_to_back();
    int wv, rv;
    do_reset();
    wv = 0; rv = 0;
    for (int i = 0; i < 8; i++) begin push(32'h5000 + 32'(wv)); wv++; end
    wr_en = 1'b1; rd_en = 1'b1;
    for (int i = 0; i < 100; i++) begin
      data_in = 32'h5000 + 32'(wv); wv++;
      cyc();
      n_cmp++; if (count !== 5'd8) begin n_bad++; $display("FAIL b2b_count[%0d] got %0d want 8", i, count); end
      n_cmp++; if (data_out !== 32'h5000 + 32'(rv)) begin n_bad++; $display("FAIL b2b_data[%0d] got %h want %h", i, data_out, 32'h5000 + 32'(rv)); end
      rv++;
    end
    idle();
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 10; i++) push(32'hC0 + 32'(i));
    rd_en = 1'b1; cyc(); rd_en = 1'b0;
    n_cmp++; if ({count, data_out} !== {5'd9, 32'hC0}) begin n_bad++; $display("FAIL mid_pre got cnt=%0d d=%h want cnt=9 d=c0", count, data_out); end
    rst = 1'b1; cyc(); rst = 1'b0;
    n_cmp++; if (count !== 5'd0) begin n_bad++; $display("FAIL mid_count got %0d want 0", count); end
    n_cmp++; if (empty !== 1'b1) begin n_bad++; $display("FAIL mid_empty got %b want 1", empty); end
    n_cmp++; if (data_out !== 32'h0) begin n_bad++; $display("FAIL mid_dout got %h want 0", data_out); end
    // Discarded words must not reappear
    push(32'hD1);
    rd_en = 1'b1; cyc(); rd_en = 1'b0;
    n_cmp++; if (data_out !== 32'hD1) begin n_bad++; $display("FAIL mid_after got %h want d1", data_out); end
  endtask

  initial begin
    rst = 1'b0; data_in = '0;
    idle();
    test_reset();
    test_fill_drain();
    test_underflow();
    test_simultaneous();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
